piradip_axis_to_axi4_writer: RTL and testbench



---
 rtl/piradip_axis_to_axi4_writer_if.sv | 50 +++++
 rtl/piradip_axis_to_axi4_writer.sv | 167 ++++++++++++++++
 tb/tb_piradip_axis_to_axi4_writer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/piradip_axis_to_axi4_writer_if.sv
// Stream-in / AXI4-write-out signal bundle for piradip_axis_to_axi4_writer.
// master: the writer (stream sink, AXI write master); slave: its environment.
interface piradip_axis_to_axi4_writer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;

  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;

  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;

  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/piradip_axis_to_axi4_writer.sv
// AXI-Stream to AXI4 circular-buffer write engine: FWFT FIFO plus single-outstanding INCR bursts.
// Optional tlast-driven short/flush bursts are enabled by defining PIRADIP_S2MM_FLUSH_EN.
module piradip_axis_to_axi4_writer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned BUF_BASE   = 0,
  parameter int unsigned BUF_BYTES  = 4096,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              enable,
  piradip_axis_to_axi4_writer_if.master     bus,
  output logic [ADDR_WIDTH-1:0]             wr_ptr,
  output logic [15:0]                       err_count
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SIZE  = $clog2(BYTES);
  localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0] BASE_A     = ADDR_WIDTH'(BUF_BASE);
  localparam logic [ADDR_WIDTH-1:0] BUFSZ_A    = ADDR_WIDTH'(BUF_BYTES);
  localparam logic [8:0]            FULL_BEATS = 9'(BURST_LEN);
  localparam logic [CW-1:0]         THRESH     = CW'(BURST_LEN);
  localparam logic [CW-1:0]         DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]         LAST_P     = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]           fifo_wp_q, fifo_rp_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    run_q;
  logic [7:0]              awlen_q, awlen_d;
  logic [7:0]              beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   offset_q, offset_d;
  logic [15:0]             err_q, err_d;

  logic                    push, pop, full, empty;
  logic                    start;
  logic [8:0]              burst_beats;
  logic [ADDR_WIDTH-1:0]   next_off;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign bus.s_axis_tready = run_q & enable & ~full;
  assign push              = bus.s_axis_tvalid & bus.s_axis_tready;
  assign pop               = bus.m_axi_wvalid & bus.m_axi_wready;

  assign bus.m_axi_awaddr  = BASE_A + offset_q;
  assign bus.m_axi_awlen   = awlen_q;
  assign bus.m_axi_awsize  = 3'(SIZE);
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awvalid = (state_q == S_ADDR);
  assign bus.m_axi_wdata   = mem_q[fifo_rp_q];
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wvalid  = (state_q == S_DATA) & ~empty;
  assign bus.m_axi_wlast   = (state_q == S_DATA) && (beat_q == awlen_q);
  assign bus.m_axi_bready  = (state_q == S_RESP);

  assign wr_ptr    = offset_q;
  assign err_count = err_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

`ifdef PIRADIP_S2MM_FLUSH_EN
  // flush_q: FIFO entries up to and including the newest accepted tlast beat.
  logic [CW-1:0]         flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] room;
  logic [8:0]            want;

  always_comb begin
    flush_d = flush_q;
    if (push && bus.s_axis_tlast) flush_d = count_d;
    else if (pop && flush_q != '0) flush_d = flush_q - CW'(1);
  end

  always_comb begin
    room        = (BUFSZ_A - offset_q) >> SIZE;
    want        = (count_q >= THRESH) ? FULL_BEATS : 9'(flush_q);
    burst_beats = (ADDR_WIDTH'(want) > room) ? 9'(room) : want;
    start       = (count_q >= THRESH) || (flush_q != '0);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) flush_q <= '0;
    else          flush_q <= flush_d;
  end
`else
  logic unused_tlast;
  assign unused_tlast = bus.s_axis_tlast;
  assign burst_beats  = FULL_BEATS;
  assign start        = (count_q >= THRESH);
`endif

  always_comb begin
    next_off = offset_q + ((ADDR_WIDTH'(awlen_q) + ADDR_WIDTH'(1)) << SIZE);
    if (next_off == BUFSZ_A) next_off = '0;
  end

  always_comb begin
    state_d  = state_q;
    awlen_d  = awlen_q;
    beat_d   = beat_q;
    offset_d = offset_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: if (enable && start) begin
        state_d = S_ADDR;
        awlen_d = 8'(burst_beats - 9'd1);
      end
      S_ADDR: if (bus.m_axi_awready) begin
        state_d = S_DATA;
        beat_d  = '0;
      end
      S_DATA: if (pop) begin
        beat_d = beat_q + 8'd1;
        if (beat_q == awlen_q) state_d = S_RESP;
      end
      S_RESP: if (bus.m_axi_bvalid) begin
        state_d  = S_IDLE;
        offset_d = next_off;
        if (bus.m_axi_bresp != 2'b00 && err_q != '1) err_d = err_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage is not reset; emptiness is defined solely by the pointers and count.
  always_ff @(posedge aclk) begin
    if (push) mem_q[fifo_wp_q] <= bus.s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      fifo_wp_q <= '0;
      fifo_rp_q <= '0;
      count_q   <= '0;
      run_q     <= 1'b0;
      awlen_q   <= 8'(BURST_LEN - 1);
      beat_q    <= '0;
      offset_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      run_q    <= 1'b1;
      awlen_q  <= awlen_d;
      beat_q   <= beat_d;
      offset_q <= offset_d;
      err_q    <= err_d;
      if (push) fifo_wp_q <= (fifo_wp_q == LAST_P) ? '0 : fifo_wp_q + PW'(1);
      if (pop)  fifo_rp_q <= (fifo_rp_q == LAST_P) ? '0 : fifo_rp_q + PW'(1);
    end
  end

endmodule

// File: tb/tb_piradip_axis_to_axi4_writer.sv
// Scoreboard bench for piradip_axis_to_axi4_writer: stream words queued on acceptance, compared on W beats.
module tb_piradip_axis_to_axi4_writer;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned BL   = 16;
  localparam int unsigned BASE = 32'h1000;
  localparam int unsigned BB   = 256;
  localparam int unsigned FD   = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b1;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   err_count;

  piradip_axis_to_axi4_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  piradip_axis_to_axi4_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL),
    .BUF_BASE(BASE), .BUF_BYTES(BB), .FIFO_DEPTH(FD)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .bus(bus.master), .wr_ptr(wr_ptr), .err_count(err_count)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] src_q[$];
  logic          lst_q[$];
  logic [DW-1:0] exp_q[$];

  int unsigned aw_delay   = 0;
  int unsigned wready_pct = 100;
  int          bad_burst  = -1;
  int          exp_len    = BL - 1;
  int unsigned exp_off    = 0;
  int          exp_err    = 0;
  int          n_aw = 0, n_b = 0, beat = 0, mcount = 0;
  int unsigned aw_wait = 0;
  bit          in_burst = 0, b_pend = 0, ptr_chk = 0, saw_full = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Inputs are driven on the falling edge; handshakes for the next rising edge are scored at negedge+1.
  initial begin
    forever begin
      @(negedge aclk);
      if (ptr_chk) begin
        check("wr_ptr", 64'(wr_ptr), 64'(exp_off));
        check("err_count", 64'(err_count), 64'(exp_err));
        ptr_chk = 0;
      end
      if (!aresetn) begin
        bus.s_axis_tvalid = 0; bus.s_axis_tdata = '0; bus.s_axis_tlast = 0;
        bus.m_axi_awready = 0; bus.m_axi_wready = 0;
        bus.m_axi_bvalid = 0; bus.m_axi_bresp = 2'b00;
        src_q.delete(); lst_q.delete(); exp_q.delete();
        mcount = 0; in_burst = 0; beat = 0; b_pend = 0; exp_off = 0; exp_err = 0;
        aw_wait = 0; n_aw = 0; n_b = 0;
      end else begin
        bus.s_axis_tvalid = (src_q.size() > 0);
        bus.s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
        bus.s_axis_tlast  = (lst_q.size() > 0) ? lst_q[0] : 1'b0;
        if (bus.m_axi_awvalid) begin
          if (aw_wait >= aw_delay) bus.m_axi_awready = 1;
          else begin bus.m_axi_awready = 0; aw_wait++; end
        end else bus.m_axi_awready = 0;
        bus.m_axi_wready = ($urandom_range(99) < wready_pct);
        bus.m_axi_bvalid = b_pend;
        bus.m_axi_bresp  = (n_b == bad_burst) ? 2'b10 : 2'b00;
        #1;
        if (mcount == int'(FD)) begin
          saw_full = 1;
          check("tready_full", 64'(bus.s_axis_tready), 64'(0));
        end
        if (bus.s_axis_tvalid && bus.s_axis_tready) begin
          exp_q.push_back(src_q.pop_front());
          void'(lst_q.pop_front());
          mcount++;
        end
        if (bus.m_axi_awvalid && bus.m_axi_awready) begin
          check("awaddr", 64'(bus.m_axi_awaddr), 64'(BASE + exp_off));
          check("awlen", 64'(bus.m_axi_awlen), 64'(exp_len));
          in_burst = 1; beat = 0; aw_wait = 0; n_aw++;
        end
        if (bus.m_axi_wvalid) check("w_after_aw", 64'(in_burst), 64'(1));
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          check("wdata_avail", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) check("wdata", 64'(bus.m_axi_wdata), 64'(exp_q.pop_front()));
          check("wlast", 64'(bus.m_axi_wlast), 64'(beat == exp_len));
          if (beat == exp_len) b_pend = 1;
          beat++;
          mcount--;
        end
        if (bus.m_axi_bvalid && bus.m_axi_bready) begin
          if (bus.m_axi_bresp != 2'b00) exp_err++;
          exp_off = (exp_off + (exp_len + 1) * (DW / 8)) % BB;
          b_pend = 0; in_burst = 0; ptr_chk = 1; n_b++;
        end
      end
    end
  end

  task automatic push_words(input int unsigned first, input int n, input bit last_at_end);
    @(posedge aclk); #2;
    for (int i = 0; i < n; i++) begin
      src_q.push_back(DW'(first + i));
      lst_q.push_back(last_at_end && (i == n - 1));
    end
  endtask

  task automatic wait_bursts(input string tag, input int n, input int budget);
    int cyc = 0;
    while (n_b < n && cyc < budget) begin @(posedge aclk); cyc++; end
    repeat (3) @(posedge aclk);
    check(tag, 64'(n_b), 64'(n));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_awvalid"}, 64'(bus.m_axi_awvalid), 64'(0));
    check({tag, "_wvalid"},  64'(bus.m_axi_wvalid),  64'(0));
    check({tag, "_wlast"},   64'(bus.m_axi_wlast),   64'(0));
    check({tag, "_bready"},  64'(bus.m_axi_bready),  64'(0));
    check({tag, "_tready"},  64'(bus.s_axis_tready), 64'(0));
    check({tag, "_awaddr"},  64'(bus.m_axi_awaddr),  64'(BASE));
    check({tag, "_awlen"},   64'(bus.m_axi_awlen),   64'(BL - 1));
    check({tag, "_wr_ptr"},  64'(wr_ptr),            64'(0));
    check({tag, "_err"},     64'(err_count),         64'(0));
  endtask

  task automatic do_reset(input string tag);
    @(posedge aclk); #2;
    aresetn = 0;
    repeat (2) @(posedge aclk);
    #1;
    check_reset_vals(tag);
    aw_delay = 0; wready_pct = 100; bad_burst = -1; exp_len = BL - 1; saw_full = 0;
    @(posedge aclk); #2;
    aresetn = 1;
  endtask

  initial begin
    bus.s_axis_tvalid = 0; bus.s_axis_tdata = '0; bus.s_axis_tlast = 0;
    bus.m_axi_awready = 0; bus.m_axi_wready = 0;
    bus.m_axi_bvalid = 0; bus.m_axi_bresp = 2'b00;

    // Basic: two bursts, wr_ptr 0x40 then 0x80 (scored per burst).
    do_reset("rst0");
    push_words(0, 32, 0);
    wait_bursts("basic_bursts", 2, 400);
    check("basic_wr_ptr", 64'(wr_ptr), 64'(32'h80));
    check("basic_sb_empty", 64'(exp_q.size()), 64'(0));

    // Wrap: fifth burst returns to BUF_BASE.
    do_reset("rst1");
    push_words(32'h100, 80, 0);
    wait_bursts("wrap_bursts", 5, 1000);
    check("wrap_wr_ptr", 64'(wr_ptr), 64'(32'h40));
    check("wrap_sb_empty", 64'(exp_q.size()), 64'(0));

    // Backpressure: slow AW, 50% wready, continuous stream fills the FIFO.
    do_reset("rst2");
    aw_delay = 5; wready_pct = 50;
    push_words(32'h200, 96, 0);
    wait_bursts("bp_bursts", 6, 3000);
    check("bp_saw_full", 64'(saw_full), 64'(1));
    check("bp_sb_empty", 64'(exp_q.size()), 64'(0));

    // Error response on the second burst; pointer still advances.
    do_reset("rst3");
    bad_burst = 1;
    push_words(32'h300, 32, 0);
    wait_bursts("err_bursts", 2, 400);
    check("err_count_final", 64'(err_count), 64'(1));
    check("err_wr_ptr", 64'(wr_ptr), 64'(32'h80));

    // Reset after 7 beats of the second burst, then restart at BUF_BASE.
    do_reset("rst4");
    push_words(32'h400, 48, 0);
    begin
      int cyc = 0;
      while (!(n_b >= 1 && in_burst && beat >= 7) && cyc < 500) begin @(posedge aclk); cyc++; end
      check("midrst_reached", 64'(beat >= 7), 64'(1));
    end
    #2 aresetn = 0;
    @(posedge aclk); #1;
    check_reset_vals("midrst");
    @(posedge aclk); #2 aresetn = 1;
    push_words(32'h500, 16, 0);
    wait_bursts("midrst_bursts", 1, 400);
    check("midrst_wr_ptr", 64'(wr_ptr), 64'(32'h40));

    // Flush: five words ending in tlast.
    do_reset("rst5");
`ifdef PIRADIP_S2MM_FLUSH_EN
    exp_len = 4;
    push_words(32'h600, 5, 1);
    wait_bursts("flush_bursts", 1, 200);
    check("flush_wr_ptr", 64'(wr_ptr), 64'(32'h14));
`else
    push_words(32'h600, 5, 1);
    repeat (40) @(posedge aclk);
    check("flush_no_aw", 64'(n_aw), 64'(0));
    check("flush_fifo_kept", 64'(exp_q.size()), 64'(5));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
